// File: rtl/toggle_gen.sv
// toggle_gen: multi-channel programmable toggle/pulse generator with shadowed config and global sync.
module toggle_gen #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 8,
  parameter int RST_PERIOD = 2,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              cfg_mode,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] tick
);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d, sh_per_q, sh_per_d;
    logic mode_q, mode_d, sh_mode_q, sh_mode_d, out_q, out_d, tick_q, tick_d;
    logic wr, wrap, ld;
    assign wr   = cfg_we && (int'(cfg_ch) == g);
    assign wrap = cnt_q == per_q;
    assign ld   = sync || !ch_en[g] || wrap;
    // A write on a load edge bypasses the shadow so the new value wins immediately.
    always_comb begin
      sh_per_d  = wr ? cfg_period : sh_per_q;
      sh_mode_d = wr ? cfg_mode : sh_mode_q;
      per_d     = ld ? sh_per_d : per_q;
      mode_d    = ld ? sh_mode_d : mode_q;
      cnt_d     = sync ? '0 : !ch_en[g] ? cnt_q : wrap ? '0 : cnt_q + CNT_W'(1);
      tick_d    = !sync && ch_en[g] && wrap;
      out_d     = sync ? 1'b0 : (ch_en[g] && wrap) ? (mode_d | ~out_q) : (out_q & ~mode_d);
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q     <= '0;
        per_q     <= CNT_W'(RST_PERIOD);
        sh_per_q  <= CNT_W'(RST_PERIOD);
        mode_q    <= 1'b0;
        sh_mode_q <= 1'b0;
        out_q     <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        per_q     <= per_d;
        sh_per_q  <= sh_per_d;
        mode_q    <= mode_d;
        sh_mode_q <= sh_mode_d;
        out_q     <= out_d;
        tick_q    <= tick_d;
      end
    end
    assign out[g]  = out_q;
    assign tick[g] = tick_q;
  end
endmodule

// File: tb/tb_toggle_gen.sv
// tb_toggle_gen: directed scoreboard bench for toggle_gen with a cycle model and spot checks.
module tb_toggle_gen;
  localparam int N = 4;
  logic clk = 0, rst_n = 0, cfg_we = 0, cfg_mode = 0, sync = 0;
  logic [1:0] cfg_ch = 0;
  logic [7:0] cfg_period = 0;
  logic [3:0] ch_en = 4'hf;
  logic [3:0] out, tick;
  int n_chk = 0, n_fail = 0;
  int m_cnt[N], m_per[N], m_sh_per[N];
  bit m_mode[N], m_sh_mode[N], m_out[N], m_tick[N];
  logic [7:0] exp_q[$];
  bit found;

  always #5 clk = ~clk;

  toggle_gen #(.NUM_CH(4), .CNT_W(8), .RST_PERIOD(2)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
    .cfg_mode(cfg_mode), .ch_en(ch_en), .sync(sync), .out(out), .tick(tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_per[i] = 2; m_sh_per[i] = 2;
      m_mode[i] = 0; m_sh_mode[i] = 0; m_out[i] = 0; m_tick[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      if (cfg_we && int'(cfg_ch) == i) begin
        m_sh_per[i] = int'(cfg_period);
        m_sh_mode[i] = cfg_mode;
      end
      if (sync) begin
        m_cnt[i] = 0; m_out[i] = 0; m_tick[i] = 0;
        m_per[i] = m_sh_per[i]; m_mode[i] = m_sh_mode[i];
      end else if (!ch_en[i]) begin
        m_tick[i] = 0;
        m_per[i] = m_sh_per[i]; m_mode[i] = m_sh_mode[i];
        if (m_mode[i]) m_out[i] = 0;
      end else if (m_cnt[i] == m_per[i]) begin
        m_cnt[i] = 0; m_tick[i] = 1;
        m_per[i] = m_sh_per[i]; m_mode[i] = m_sh_mode[i];
        m_out[i] = m_mode[i] ? 1'b1 : !m_out[i];
      end else begin
        m_cnt[i]++; m_tick[i] = 0;
        if (m_mode[i]) m_out[i] = 0;
      end
    end
  endtask

  task automatic step(input string tag);
    logic [7:0] e;
    model_edge();
    for (int i = 0; i < N; i++) begin
      e[4+i] = m_out[i];
      e[i] = m_tick[i];
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    chk(tag, {out, tick}, exp_q.pop_front());
  endtask

  task automatic wr(input int ch, input int p, input bit m);
    cfg_we = 1; cfg_ch = 2'(ch); cfg_period = 8'(p); cfg_mode = m;
    step("cfg_write");
    cfg_we = 0;
  endtask

  initial begin
    mreset();
    #12;
    chk("reset_out_tick", {out, tick}, 8'h00);
    rst_n = 1;
    for (int e = 1; e <= 9; e++) begin
      step("run_default");
      chk("def_tick", tick, (e % 3 == 0) ? 4'hf : 4'h0);
      chk("def_out0", out[0], (e / 3) % 2);
    end
    wr(1, 3, 1);
    sync = 1; step("sync1"); sync = 0;
    for (int k = 1; k <= 12; k++) begin
      step("pulse_run");
      chk("pulse_tick1", tick[1], k % 4 == 0);
      chk("pulse_out1", out[1], k % 4 == 0);
    end
    step("ch2_cnt1");
    wr(2, 5, 0);
    step("ch2_oldwrap");
    chk("ch2_old_wrap", tick[2], 1);
    for (int k = 1; k <= 6; k++) begin
      step("ch2_newper");
      chk("ch2_new_interval", tick[2], k == 6);
    end
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (m_out[3] && m_cnt[3] == 1) found = 1;
      else step("ch3_seek");
    end
    chk("ch3_seek", found, 1);
    ch_en[3] = 0;
    for (int k = 0; k < 10; k++) begin
      step("ch3_off");
      chk("ch3_hold_out", out[3], 1);
      chk("ch3_hold_tick", tick[3], 0);
    end
    ch_en[3] = 1;
    step("ch3_resume");
    chk("ch3_resume_notick", tick[3], 0);
    step("ch3_resume_wrap");
    chk("ch3_resume_wrap", tick[3], 1);
    wr(0, 0, 0);
    wr(1, 255, 0);
    sync = 1; step("sync2"); sync = 0;
    for (int k = 1; k <= 256; k++) begin
      step("p0_p255");
      chk("p0_out0", out[0], k % 2);
      chk("p255_tick1", tick[1], k == 256);
    end
    wr(0, 7, 0);
    sync = 1; step("sync3"); sync = 0;
    for (int k = 0; k < 3; k++) step("pre_reset");
    chk("pre_reset_active", out[3], 1);
    #2 rst_n = 0;
    #1 chk("async_reset", {out, tick}, 8'h00);
    mreset();
    @(negedge clk);
    rst_n = 1;
    for (int e = 1; e <= 3; e++) begin
      step("post_reset");
      chk("post_reset_tick0", tick[0], e == 3);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
